// File: rtl/psum_adder_ctrl.sv
// Feeds PE psum vectors to the psum adder, stamping each with its ofmap address.
// Optional stall counter: define PSUM_CTRL_PERF_EN.
module psum_adder_ctrl #(
  parameter int PSUM_IN_WIDTH          = 1536,
  parameter int OFMAPS_BRAM_ADDR_WIDTH = 12
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [7:0]                        in_channel,
  input  logic [2:0]                        kernel_size,
  input  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] ofmap_words,
  input  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] base_addr,
  input  logic                              pe_valid,
  input  logic [PSUM_IN_WIDTH-1:0]          pe_psum,
  output logic                              pe_ready,
  output logic [PSUM_IN_WIDTH-1:0]          psum_in,
  output logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] address_in,
  output logic                              i_valid,
  output logic                              layer_finish,
  input  logic                              o_last,
  output logic                              busy,
  output logic                              done,
`ifdef PSUM_CTRL_PERF_EN
  output logic [15:0]                       stall_cycles,
`endif
  output logic                              cfg_err
);

  localparam int AW = OFMAPS_BRAM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    WAIT_LAST
  } state_t;

  state_t state, state_nx;

  logic [10:0]   bpw_q;
  logic [10:0]   beat_cnt;
  logic [AW-1:0] words_q;
  logic [AW-1:0] base_q;
  logic [AW-1:0] word_idx;

  logic cfg_ok;
  logic accept;
  logic beat;
  logic word_end;
  logic last_beat;

  assign cfg_ok    = (|in_channel) && (|kernel_size) && (|ofmap_words);
  assign accept    = (state == IDLE) && start && cfg_ok;
  assign beat      = (state == RUN) && pe_valid;
  assign word_end  = (beat_cnt == bpw_q - 11'd1);
  assign last_beat = beat && word_end && (word_idx == words_q - AW'(1));

  assign pe_ready = (state == RUN);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (accept) state_nx = RUN;
      RUN:       if (last_beat) state_nx = FLUSH;
      FLUSH:     state_nx = WAIT_LAST;
      WAIT_LAST: if (o_last) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Product is at most 255*7 = 1785, so 11 bits never truncate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bpw_q    <= '0;
      words_q  <= '0;
      base_q   <= '0;
      beat_cnt <= '0;
      word_idx <= '0;
    end else if (accept) begin
      bpw_q    <= 11'(in_channel) * 11'(kernel_size);
      words_q  <= ofmap_words;
      base_q   <= base_addr;
      beat_cnt <= '0;
      word_idx <= '0;
    end else if (beat) begin
      if (word_end) begin
        beat_cnt <= '0;
        word_idx <= word_idx + AW'(1);
      end else begin
        beat_cnt <= beat_cnt + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_valid      <= 1'b0;
      psum_in      <= '0;
      address_in   <= '0;
      layer_finish <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      i_valid      <= beat;
      layer_finish <= (state == FLUSH);
      done         <= (state == WAIT_LAST) && o_last;
      cfg_err      <= (state == IDLE) && start && !cfg_ok;
      if (beat) begin
        psum_in    <= pe_psum;
        address_in <= base_q + word_idx;
      end
    end
  end

`ifdef PSUM_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (accept)
      stall_cycles <= '0;
    else if ((state == RUN) && !pe_valid && (stall_cycles != 16'hFFFF))
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_psum_adder_ctrl.sv
// Directed table-driven bench for psum_adder_ctrl.
// Build with +define+PSUM_CTRL_PERF_EN to also check stall_cycles.
module tb_psum_adder_ctrl;

  localparam int PW = 1536;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    in_channel;
  logic [2:0]    kernel_size;
  logic [AW-1:0] ofmap_words;
  logic [AW-1:0] base_addr;
  logic          pe_valid;
  logic [PW-1:0] pe_psum;
  logic          pe_ready;
  logic [PW-1:0] psum_in;
  logic [AW-1:0] address_in;
  logic          i_valid;
  logic          layer_finish;
  logic          o_last;
  logic          busy;
  logic          done;
  logic          cfg_err;
`ifdef PSUM_CTRL_PERF_EN
  logic [15:0]   stall_cycles;
`endif

  always #5 clk = ~clk;

  psum_adder_ctrl #(
    .PSUM_IN_WIDTH(PW),
    .OFMAPS_BRAM_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .in_channel(in_channel),
    .kernel_size(kernel_size),
    .ofmap_words(ofmap_words),
    .base_addr(base_addr),
    .pe_valid(pe_valid),
    .pe_psum(pe_psum),
    .pe_ready(pe_ready),
    .psum_in(psum_in),
    .address_in(address_in),
    .i_valid(i_valid),
    .layer_finish(layer_finish),
    .o_last(o_last),
    .busy(busy),
    .done(done),
`ifdef PSUM_CTRL_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .cfg_err(cfg_err)
  );

  typedef struct {
    logic [7:0]    ic;
    logic [2:0]    ks;
    logic [AW-1:0] words;
    logic [AW-1:0] base;
    bit            tog;
    bit            noise;
    bit            err;
    int            beats;
    logic [AW-1:0] a_first;
    logic [AW-1:0] a_last;
    int            stall;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, pe_ready, 0);
    chk({tag, "_ival"}, i_valid, 0);
    chk({tag, "_lfin"}, layer_finish, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cerr"}, cfg_err, 0);
    chk({tag, "_addr"}, address_in, 0);
    chk({tag, "_psum"}, (psum_in == '0), 1);
`ifdef PSUM_CTRL_PERF_EN
    chk({tag, "_stall"}, stall_cycles, 0);
`endif
  endtask

  function automatic logic [PW-1:0] rnd_psum();
    logic [PW-1:0] p;
    for (int k = 0; k < PW / 32; k++) p[k*32 +: 32] = $urandom();
    return p;
  endfunction

  task automatic run_layer(input vec_t v, input string nm);
    logic [PW-1:0] q[$];
    logic [PW-1:0] ep;
    logic [AW-1:0] ea;
    logic [AW-1:0] first_a;
    logic [AW-1:0] last_a;
    int            beats;
    int            stalls;
    int            bpw;
    int            cyc;
    bit            prev_iv;
    bit            lf_seen;
    bit            pv;
    int            ev;

    bpw     = int'(v.ic) * int'(v.ks);
    beats   = 0;
    stalls  = 0;
    prev_iv = 0;
    lf_seen = 0;
    first_a = '0;
    last_a  = '0;

    @(negedge clk);
    start       = 1'b1;
    in_channel  = v.ic;
    kernel_size = v.ks;
    ofmap_words = v.words;
    base_addr   = v.base;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_cfg_err"}, cfg_err, v.err);
    chk({nm, "_busy_go"}, busy, !v.err);

    if (v.err) begin
      ev = 0;
      repeat (4) begin
        @(negedge clk);
        ev += int'(i_valid) + int'(layer_finish) + int'(busy) + int'(cfg_err);
      end
      chk({nm, "_err_quiet"}, ev, 0);
      return;
    end

    for (cyc = 0; cyc < 4000; cyc++) begin
      if (i_valid) begin
        ea = v.base + AW'(beats / bpw);
        chk({nm, "_addr"}, address_in, ea);
        ep = q.size() > 0 ? q.pop_front() : '0;
        chk({nm, "_psum"}, (psum_in == ep), 1);
        if (beats == 0) first_a = address_in;
        last_a = address_in;
        beats++;
      end
      if (layer_finish) begin
        lf_seen = 1;
        chk({nm, "_lfin_after_last"}, prev_iv, 1);
        break;
      end
      prev_iv = i_valid;
      pv       = v.tog ? (cyc % 2 == 0) : 1'b1;
      pe_valid = pv;
      pe_psum  = rnd_psum();
      if (pe_ready && pv) q.push_back(pe_psum);
      if (pe_ready && !pv) stalls++;
      if (v.noise && cyc == 3) begin
        start       = 1'b1;
        in_channel  = 8'd1;
        kernel_size = 3'd1;
        ofmap_words = 12'd1;
        base_addr   = 12'h555;
        o_last      = 1'b1;
      end else begin
        start  = 1'b0;
        o_last = 1'b0;
      end
      @(negedge clk);
    end
    pe_valid = 1'b0;
    start    = 1'b0;
    o_last   = 1'b0;

    chk({nm, "_lfin_seen"}, lf_seen, 1);
    chk({nm, "_beats"}, beats, v.beats);
    chk({nm, "_first_addr"}, first_a, v.a_first);
    chk({nm, "_last_addr"}, last_a, v.a_last);
    chk({nm, "_stall_model"}, stalls, v.stall);
`ifdef PSUM_CTRL_PERF_EN
    chk({nm, "_stall_cycles"}, stall_cycles, v.stall);
`endif
    chk({nm, "_wait_ready"}, pe_ready, 0);
    chk({nm, "_wait_busy"}, busy, 1);

    @(negedge clk);
    chk({nm, "_lfin_pulse"}, layer_finish, 0);
    chk({nm, "_no_early_done"}, done, 0);
    @(negedge clk);
    o_last = 1'b1;
    @(negedge clk);
    o_last = 1'b0;
    chk({nm, "_done"}, done, 1);
    chk({nm, "_idle"}, busy, 0);
    @(negedge clk);
    chk({nm, "_done_pulse"}, done, 0);
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    tbl[0] = '{8'd2, 3'd5, 12'd3, 12'hAB2, 0, 0, 0, 30, 12'hAB2, 12'hAB4, 0};
    tbl[1] = '{8'd1, 3'd1, 12'd2, 12'hFFF, 0, 0, 0, 2, 12'hFFF, 12'h000, 0};
    tbl[2] = '{8'd3, 3'd0, 12'd2, 12'h010, 0, 0, 1, 0, 12'h000, 12'h000, 0};
    tbl[3] = '{8'd1, 3'd1, 12'd3, 12'h100, 1, 0, 0, 3, 12'h100, 12'h102, 2};
    tbl[4] = '{8'd2, 3'd5, 12'd3, 12'hAB2, 0, 1, 0, 30, 12'hAB2, 12'hAB4, 0};
    tbl[5] = '{8'd0, 3'd3, 12'd1, 12'h020, 0, 0, 1, 0, 12'h000, 12'h000, 0};
    tbl[6] = '{8'd255, 3'd7, 12'd1, 12'h000, 0, 0, 0, 1785, 12'h000, 12'h000, 0};
    tbl[7] = '{8'd1, 3'd2, 12'd0, 12'h030, 0, 0, 1, 0, 12'h000, 12'h000, 0};

    rst_n       = 1'b0;
    start       = 1'b0;
    in_channel  = '0;
    kernel_size = '0;
    ofmap_words = '0;
    base_addr   = '0;
    pe_valid    = 1'b0;
    pe_psum     = '0;
    o_last      = 1'b0;

    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    o_last = 1'b1;
    @(negedge clk);
    o_last = 1'b0;
    chk("idle_olast_done", done, 0);
    chk("idle_olast_busy", busy, 0);

    for (int i = 0; i < 8; i++) run_layer(tbl[i], $sformatf("v%0d", i));

    begin : mid_reset
      int ivs;
      int cyc;
      ivs = 0;
      @(negedge clk);
      start       = 1'b1;
      in_channel  = 8'd2;
      kernel_size = 3'd5;
      ofmap_words = 12'd1;
      base_addr   = 12'h020;
      @(negedge clk);
      start    = 1'b0;
      pe_valid = 1'b1;
      pe_psum  = rnd_psum();
      for (cyc = 0; cyc < 50 && ivs < 7; cyc++) begin
        @(negedge clk);
        if (i_valid) ivs++;
      end
      chk("mrst_seven_beats", ivs, 7);
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("mrst");
      @(negedge clk);
      pe_valid = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      chk("mrst_no_resume", busy, 0);
      rv = '{8'd2, 3'd5, 12'd1, 12'h020, 0, 0, 0, 10, 12'h020, 12'h020, 0};
      run_layer(rv, "mrst_relaunch");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_adder_ctrl.md
PSUM_ADDER_CTRL -- requirements
Module: psum_adder_ctrl

Interface
REQ-001 SHALL have parameter PSUM_IN_WIDTH, default 1536 (6*256), width of one psum vector.
REQ-002 SHALL have parameter OFMAPS_BRAM_ADDR_WIDTH, default 12, ofmap BRAM address width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that launches a layer; sampled only in IDLE.
REQ-006 SHALL have port in_channel  input  8  input channel count; latched on accepted start.
REQ-007 SHALL have port kernel_size  input  3  kernel rows per channel; latched on accepted start.
REQ-008 SHALL have port ofmap_words  input  OFMAPS_BRAM_ADDR_WIDTH  output addresses in the layer; latched on accepted start.
REQ-009 SHALL have port base_addr  input  OFMAPS_BRAM_ADDR_WIDTH  first ofmap address; latched on accepted start.
REQ-010 SHALL have port pe_valid  input  1  PE array psum vector valid.
REQ-011 SHALL have port pe_psum  input  PSUM_IN_WIDTH  PE array psum vector.
REQ-012 SHALL have port pe_ready  output  1  controller accepts a vector; beat = pe_valid & pe_ready.
REQ-013 SHALL have port psum_in  output  PSUM_IN_WIDTH  registered vector to the psum adder.
REQ-014 SHALL have port address_in  output  OFMAPS_BRAM_ADDR_WIDTH  registered address stamped on psum_in.
REQ-015 SHALL have port i_valid  output  1  registered beat strobe to the psum adder.
REQ-016 SHALL have port layer_finish  output  1  one-cycle pulse to the psum adder after the last beat.
REQ-017 SHALL have port o_last  input  1  psum adder final-word indication.
REQ-018 SHALL have ports busy  output  1, done  output  1 (one-cycle pulse), cfg_err  output  1 (one-cycle pulse).

Function
REQ-019 SHALL implement states IDLE, RUN, FLUSH, WAIT_LAST.
REQ-020 IDLE: start with in_channel, kernel_size and ofmap_words all nonzero -> RUN; if any is zero -> pulse cfg_err next cycle, stay IDLE.
REQ-021 pe_ready SHALL equal (state==RUN); busy SHALL equal (state!=IDLE).
REQ-022 beats_per_word SHALL be in_channel*kernel_size, computed unsigned at 11 bits (max 1785), no truncation.
REQ-023 Each beat SHALL, one cycle later, drive i_valid=1, psum_in=pe_psum, address_in=(base_addr+word_idx) mod 2^OFMAPS_BRAM_ADDR_WIDTH; i_valid=0 otherwise, and psum_in/address_in SHALL hold their last values.
REQ-024 beat_cnt SHALL increment per beat; at beats_per_word-1 it SHALL clear and word_idx SHALL increment.
REQ-025 The beat that completes word ofmap_words-1 SHALL move RUN -> FLUSH; no further beats are accepted.
REQ-026 FLUSH SHALL last one cycle, asserting layer_finish (the cycle after the final i_valid), then -> WAIT_LAST.
REQ-027 WAIT_LAST SHALL wait for o_last=1, then pulse done for one cycle and -> IDLE.
REQ-028 o_last outside WAIT_LAST SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-029 pe_valid gaps in RUN SHALL stall counters without emitting i_valid.

Reset
REQ-030 On rst_n=0, at any time including mid-layer: state=IDLE, counters and latched config=0, i_valid=layer_finish=done=cfg_err=0, psum_in=0, address_in=0, pe_ready=0, busy=0.
REQ-031 A layer interrupted by reset SHALL NOT be resumed; a new start is required.

Configuration
REQ-032 Macro PSUM_CTRL_PERF_EN defined: add output stall_cycles [15:0], cleared on accepted start, incremented each RUN cycle with pe_valid=0, saturating at 16'hFFFF, reset to 0.
REQ-033 Macro undefined: port stall_cycles and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-034 in_channel=2, kernel_size=5, ofmap_words=3, base_addr=12'hAB2, pe_valid held high -> 30 i_valid beats, 10 each at AB2/AB3/AB4, layer_finish one cycle after 30th beat, done 1 cycle after o_last.
REQ-035 base_addr=12'hFFF, ofmap_words=2, in_channel=1, kernel_size=1 -> addresses FFF then 000.
REQ-036 start with kernel_size=0 -> cfg_err pulse, busy stays 0, no i_valid, no layer_finish.
REQ-037 rst_n low after 7 of 10 beats -> all outputs 0 within reset; subsequent start runs a full 10-beat layer.
REQ-038 pe_valid toggling 1,0,1,0 -> i_valid only after valid beats; with PSUM_CTRL_PERF_EN, stall_cycles counts the low cycles.
REQ-039 start during RUN and o_last during RUN -> both ignored; beat count and address sequence unchanged.
